// File: rtl/obi_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin OBI arbiter.
// Holds the OBI request/response structs, the ID-width helper, the default
// outstanding-transaction depth and the lock state encoding.
package obi_rr_arbiter_pkg;

    // Number of cores; the arbiter is sized for the cores plus one external master.
    localparam int NHARTS = 2;

    // Default depth of the in-order ID FIFO.
    localparam int DEFAULT_MAX_OUTSTANDING = 2;

    // Width needed to hold a master index; never narrower than one bit.
    function automatic int id_width(input int n_masters);
        return (n_masters > 1) ? $clog2(n_masters) : 1;
    endfunction

    localparam int ARB_ID_W = id_width(NHARTS + 1);

    typedef logic [ARB_ID_W-1:0] arb_id_t;

    // OBI address-phase request.
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    // OBI grant and response phase.
    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    // Address-phase lock: held while the slave stalls the current winner.
    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_t;

endpackage

// File: rtl/obi_rr_arbiter_if.sv
// Bus bundle around the arbiter: all master request/response links plus the
// single shared slave link. The "slave" modport is the arbiter's view; the
// "master" modport is the view of whatever drives the masters and models the
// slave (the surrounding bus system or a testbench).
interface obi_rr_arbiter_if
    import obi_rr_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 3
);

    obi_req_t  [N_MASTERS-1:0] master_req_i;
    obi_resp_t [N_MASTERS-1:0] master_resp_o;
    obi_req_t                  slave_req_o;
    obi_resp_t                 slave_resp_i;

    modport master (
        output master_req_i,
        output slave_resp_i,
        input  master_resp_o,
        input  slave_req_o
    );

    modport slave (
        input  master_req_i,
        input  slave_resp_i,
        output master_resp_o,
        output slave_req_o
    );

endinterface

// File: rtl/obi_arb_id_fifo.sv
// Circular FIFO of master IDs, one entry per accepted-but-unanswered
// transaction. Depth need not be a power of two: pointers wrap explicitly.
// Pushes while full and pops while empty are ignored.
module obi_arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int ID_W  = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic [ID_W-1:0]                push_id_i,
    input  logic                           pop_i,
    output logic [ID_W-1:0]                head_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o    = (r_count == CNT_W'(DEPTH));
    assign empty_o   = (r_count == '0);
    assign count_o   = r_count;
    assign head_o    = r_mem[r_rd_ptr];
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    // Store the pushed ID at the write pointer.
    // NOTE: storage is deliberately not reset; the occupancy counter decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_id_i;
        end
    end

    // Advance pointers and track occupancy; a simultaneous push and pop leaves it unchanged.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/obi_rr_arbiter.sv
// N-to-1 OBI arbiter. Round-robin selection on the address phase, with a
// lock that keeps a stalled winner selected until its grant. Every accepted
// transaction's master ID is queued in order so each response is routed back
// to the master that issued it. Grant and response are zero-latency paths.
module obi_rr_arbiter
    import obi_rr_arbiter_pkg::*;
#(
    parameter int N_MASTERS       = 3,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic             clk_i,
    input  logic             rst_i,
    obi_rr_arbiter_if.slave  bus,
    output logic             busy_o,
    output logic             err_o
);

    localparam int ID_W  = id_width(N_MASTERS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  r_lock_id;
    lock_state_t      r_lock_state;
    logic             r_err;

    logic [ID_W-1:0]  w_lock_id_nxt;
    lock_state_t      w_lock_state_nxt;
    logic [ID_W-1:0]  w_winner;
    logic             w_found;
    logic             w_hs;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [ID_W-1:0]  w_head;
    logic [CNT_W-1:0] w_count;

    // Pick the winner: a locked master that still requests, else the first requester from the pointer upward.
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        if (r_lock_state == LOCK_HELD && bus.master_req_i[r_lock_id].req) begin
            w_found  = 1'b1;
            w_winner = r_lock_id;
        end else begin
            // Scanning downward lets the last hit be the one closest to the pointer.
            for (int i = N_MASTERS - 1; i >= 0; i--) begin
                if (bus.master_req_i[(int'(r_rr_ptr) + i) % N_MASTERS].req) begin
                    w_found  = 1'b1;
                    w_winner = ID_W'((int'(r_rr_ptr) + i) % N_MASTERS);
                end
            end
        end
    end

    // Forward the winner's request; a full ID FIFO or reset blocks the request.
    always_comb begin
        bus.slave_req_o = '0;
        if (w_found && !rst_i) begin
            bus.slave_req_o     = bus.master_req_i[w_winner];
            bus.slave_req_o.req = !w_full;
        end
    end

    assign w_hs  = bus.slave_req_o.req && bus.slave_resp_i.gnt;
    assign w_pop = bus.slave_resp_i.rvalid && !w_empty;

    // Route the grant to the winner and the response to the oldest outstanding master.
    always_comb begin
        bus.master_resp_o = '0;
        if (w_hs) begin
            bus.master_resp_o[w_winner].gnt = 1'b1;
        end
        if (w_pop) begin
            bus.master_resp_o[w_head].rvalid = 1'b1;
            bus.master_resp_o[w_head].rdata  = bus.slave_resp_i.rdata;
        end
    end

    // In-order record of which master owns each outstanding transaction.
    obi_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .ID_W  (ID_W)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (w_hs),
        .push_id_i (w_winner),
        .pop_i     (w_pop),
        .head_o    (w_head),
        .full_o    (w_full),
        .empty_o   (w_empty),
        .count_o   (w_count)
    );

    // Move the round-robin pointer past the master that just completed its address phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
        end else if (w_hs) begin
            r_rr_ptr <= (w_winner == ID_W'(N_MASTERS - 1)) ? '0 : w_winner + 1'b1;
        end
    end

    // Lock state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lock_state <= LOCK_IDLE;
            r_lock_id    <= '0;
        end else begin
            r_lock_state <= w_lock_state_nxt;
            r_lock_id    <= w_lock_id_nxt;
        end
    end

    // Hold the lock only while the slave is stalling an offered request; a handshake, a
    // full-FIFO block or a dropped request all release it.
    always_comb begin
        w_lock_state_nxt = LOCK_IDLE;
        w_lock_id_nxt    = r_lock_id;
        if (bus.slave_req_o.req && !bus.slave_resp_i.gnt) begin
            w_lock_state_nxt = LOCK_HELD;
            w_lock_id_nxt    = w_winner;
        end
    end

    // Sticky flag for a response that arrives with nothing outstanding.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (bus.slave_resp_i.rvalid && w_empty) begin
            r_err <= 1'b1;
        end
    end

    assign busy_o = (w_count != '0);
    assign err_o  = r_err;

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Testbench for obi_rr_arbiter: a directed table, hand-written corner
// sequences and a randomized run, all also compared cycle by cycle against a
// queue-based reference model of the arbitration and response routing.
module tb_obi_rr_arbiter;
    import obi_rr_arbiter_pkg::*;

    localparam int N    = 3;
    localparam int MAXO = 2;

    logic clk;
    logic rst;
    logic busy;
    logic err;

    obi_rr_arbiter_if #(.N_MASTERS(N)) bus ();

    obi_rr_arbiter #(
        .N_MASTERS       (N),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .busy_o (busy),
        .err_o  (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: outstanding owners in issue order, next preferred master,
    // stalled master (-1 when none) and the sticky error.
    int        m_q[$];
    int        m_rr;
    int        m_lock;
    bit        m_err;
    int        m_win;
    bit        m_hs;
    bit        m_pop;
    bit        m_spur;
    obi_req_t  exp_sreq;
    obi_resp_t [N-1:0] exp_mresp;
    bit        exp_busy;

    typedef struct {
        logic [N-1:0] req;
        logic         gnt;
        logic         rv;
        logic [31:0]  rdata;
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_rv;
        logic         exp_busy;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] gnt_mask();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = bus.master_resp_o[i].gnt;
        return m;
    endfunction

    function automatic logic [N-1:0] rv_mask();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = bus.master_resp_o[i].rvalid;
        return m;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_rr   = 0;
        m_lock = -1;
        m_err  = 1'b0;
    endtask

    // Expected outputs for the current inputs and model state.
    task automatic model_eval();
        bit full;
        if (rst) model_reset();
        m_win = -1;
        if (!rst) begin
            if (m_lock >= 0 && bus.master_req_i[m_lock].req) begin
                m_win = m_lock;
            end else begin
                for (int i = 0; i < N && m_win < 0; i++) begin
                    if (bus.master_req_i[(m_rr + i) % N].req) m_win = (m_rr + i) % N;
                end
            end
        end
        full     = (m_q.size() >= MAXO);
        exp_sreq = '0;
        if (m_win >= 0) begin
            exp_sreq     = bus.master_req_i[m_win];
            exp_sreq.req = !full;
        end
        m_hs      = exp_sreq.req && bus.slave_resp_i.gnt;
        m_pop     = !rst && bus.slave_resp_i.rvalid && (m_q.size() > 0);
        m_spur    = !rst && bus.slave_resp_i.rvalid && (m_q.size() == 0);
        exp_mresp = '0;
        if (m_hs) exp_mresp[m_win].gnt = 1'b1;
        if (m_pop) begin
            exp_mresp[m_q[0]].rvalid = 1'b1;
            exp_mresp[m_q[0]].rdata  = bus.slave_resp_i.rdata;
        end
        exp_busy = (m_q.size() > 0);
    endtask

    // State update at the clock edge.
    task automatic model_commit();
        if (rst) begin
            model_reset();
        end else begin
            if (m_pop) void'(m_q.pop_front());
            if (m_spur) m_err = 1'b1;
            if (m_hs) begin
                m_q.push_back(m_win);
                m_rr = (m_win + 1) % N;
            end
            m_lock = (exp_sreq.req && !bus.slave_resp_i.gnt) ? m_win : -1;
        end
    endtask

    // Compare against the model, then cross one rising edge.
    task automatic step();
        model_eval();
        check("slave_req", 256'(bus.slave_req_o), 256'(exp_sreq));
        check("master_resp", 256'(bus.master_resp_o), 256'(exp_mresp));
        check("busy", 256'(busy), 256'(exp_busy));
        check("err", 256'(err), 256'(m_err));
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // Apply request bits and slave response, then let combinational paths settle.
    task automatic drive(input logic [N-1:0] req, input logic gnt, input logic rv, input logic [31:0] rdata);
        for (int i = 0; i < N; i++) bus.master_req_i[i].req = req[i];
        bus.slave_resp_i.gnt    = gnt;
        bus.slave_resp_i.rvalid = rv;
        bus.slave_resp_i.rdata  = rdata;
        #3;
    endtask

    initial begin
        // All masters request, slave always grants and answers one cycle later.
        tbl[0] = '{3'b111, 1'b1, 1'b0, 32'h0,  3'b001, 3'b000, 1'b0};
        tbl[1] = '{3'b111, 1'b1, 1'b1, 32'hA0, 3'b010, 3'b001, 1'b1};
        tbl[2] = '{3'b111, 1'b1, 1'b1, 32'hA1, 3'b100, 3'b010, 1'b1};
        tbl[3] = '{3'b111, 1'b1, 1'b1, 32'hA2, 3'b001, 3'b100, 1'b1};
        tbl[4] = '{3'b111, 1'b1, 1'b1, 32'hA3, 3'b010, 3'b001, 1'b1};
        tbl[5] = '{3'b111, 1'b1, 1'b1, 32'hA4, 3'b100, 3'b010, 1'b1};
        tbl[6] = '{3'b000, 1'b1, 1'b1, 32'hA5, 3'b000, 3'b100, 1'b1};
        tbl[7] = '{3'b000, 1'b0, 1'b0, 32'h0,  3'b000, 3'b000, 1'b0};

        rst = 1'b1;
        bus.slave_resp_i = '0;
        for (int i = 0; i < N; i++) begin
            bus.master_req_i[i].req   = 1'b0;
            bus.master_req_i[i].we    = i[0];
            bus.master_req_i[i].be    = 4'hF;
            bus.master_req_i[i].addr  = 32'h2000_0000 + 32'h10 * 32'(i);
            bus.master_req_i[i].wdata = 32'hD0 + 32'(i);
        end
        model_reset();

        // Reset values.
        #2;
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check("rst_slave_req", 256'(bus.slave_req_o), 256'(0));
        check("rst_master_resp", 256'(bus.master_resp_o), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin order and response routing.
        for (int v = 0; v < 8; v++) begin
            drive(tbl[v].req, tbl[v].gnt, tbl[v].rv, tbl[v].rdata);
            check($sformatf("tbl%0d_gnt", v), 256'(gnt_mask()), 256'(tbl[v].exp_gnt));
            check($sformatf("tbl%0d_rvalid", v), 256'(rv_mask()), 256'(tbl[v].exp_rv));
            check($sformatf("tbl%0d_busy", v), 256'(busy), 256'(tbl[v].exp_busy));
            for (int i = 0; i < N; i++) begin
                if (tbl[v].exp_rv[i])
                    check($sformatf("tbl%0d_rdata%0d", v, i), 256'(bus.master_resp_o[i].rdata), 256'(tbl[v].rdata));
            end
            step();
        end

        // Stalled master 1 stays selected while master 0 joins; master 0 wins next.
        drive(3'b010, 1'b0, 1'b0, 32'h0);
        check("lock_addr0", 256'(bus.slave_req_o.addr), 256'(32'h2000_0010));
        check("lock_gnt0", 256'(gnt_mask()), 256'(0));
        step();
        for (int c = 1; c < 3; c++) begin
            drive(3'b011, 1'b0, 1'b0, 32'h0);
            check($sformatf("lock_addr%0d", c), 256'(bus.slave_req_o.addr), 256'(32'h2000_0010));
            check($sformatf("lock_req%0d", c), 256'(bus.slave_req_o.req), 256'(1));
            step();
        end
        drive(3'b011, 1'b1, 1'b0, 32'h0);
        check("lock_release_gnt", 256'(gnt_mask()), 256'(3'b010));
        step();
        drive(3'b011, 1'b1, 1'b0, 32'h0);
        check("after_lock_gnt", 256'(gnt_mask()), 256'(3'b001));
        step();
        drive(3'b000, 1'b0, 1'b1, 32'hB1);
        check("lock_resp1", 256'(rv_mask()), 256'(3'b010));
        step();
        drive(3'b000, 1'b0, 1'b1, 32'hB0);
        check("lock_resp0", 256'(rv_mask()), 256'(3'b001));
        step();

        // FIFO full blocks the third request, even with a pop in the same cycle.
        drive(3'b111, 1'b1, 1'b0, 32'h0);
        check("full_g1", 256'(gnt_mask()), 256'(3'b010));
        step();
        drive(3'b111, 1'b1, 1'b0, 32'h0);
        check("full_g2", 256'(gnt_mask()), 256'(3'b100));
        step();
        drive(3'b111, 1'b1, 1'b0, 32'h0);
        check("full_req", 256'(bus.slave_req_o.req), 256'(0));
        check("full_busy", 256'(busy), 256'(1));
        check("full_gnt", 256'(gnt_mask()), 256'(0));
        step();
        drive(3'b111, 1'b1, 1'b1, 32'hC1);
        check("full_pop_req", 256'(bus.slave_req_o.req), 256'(0));
        check("full_pop_rv", 256'(rv_mask()), 256'(3'b010));
        step();
        drive(3'b111, 1'b1, 1'b0, 32'h0);
        check("full_resume_gnt", 256'(gnt_mask()), 256'(3'b001));
        step();

        // Push and pop together at occupancy 1.
        drive(3'b000, 1'b0, 1'b1, 32'hC2);
        check("pp_drain_rv", 256'(rv_mask()), 256'(3'b100));
        step();
        drive(3'b010, 1'b1, 1'b1, 32'hC0);
        check("pp_gnt", 256'(gnt_mask()), 256'(3'b010));
        check("pp_rv_old", 256'(rv_mask()), 256'(3'b001));
        check("pp_rdata", 256'(bus.master_resp_o[0].rdata), 256'(32'hC0));
        step();
        drive(3'b000, 1'b0, 1'b1, 32'hC3);
        check("pp_busy_kept", 256'(busy), 256'(1));
        check("pp_rv_new", 256'(rv_mask()), 256'(3'b010));
        step();
        drive(3'b000, 1'b0, 1'b0, 32'h0);
        check("pp_idle_busy", 256'(busy), 256'(0));
        step();

        // Spurious response with nothing outstanding.
        drive(3'b000, 1'b0, 1'b1, 32'hEE);
        check("spur_rv", 256'(rv_mask()), 256'(0));
        step();
        for (int c = 0; c < 2; c++) begin
            drive(3'b000, 1'b0, 1'b0, 32'h0);
            check($sformatf("spur_err%0d", c), 256'(err), 256'(1));
            step();
        end

        // Asynchronous reset with two transactions outstanding.
        drive(3'b001, 1'b1, 1'b0, 32'h0);
        step();
        drive(3'b001, 1'b1, 1'b0, 32'h0);
        check("pre_rst_busy", 256'(busy), 256'(1));
        step();
        drive(3'b111, 1'b1, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        check("arst_busy", 256'(busy), 256'(0));
        check("arst_err", 256'(err), 256'(0));
        check("arst_slave_req", 256'(bus.slave_req_o), 256'(0));
        check("arst_master_resp", 256'(bus.master_resp_o), 256'(0));
        step();
        rst = 1'b0;
        drive(3'b000, 1'b0, 1'b1, 32'h55);
        check("late_rv", 256'(rv_mask()), 256'(0));
        step();
        drive(3'b111, 1'b1, 1'b0, 32'h0);
        check("late_err", 256'(err), 256'(1));
        check("ptr_restart_gnt", 256'(gnt_mask()), 256'(3'b001));
        step();

        // Randomized traffic against the model, with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.master_req_i[i].we    = 1'($urandom);
                    bus.master_req_i[i].be    = 4'($urandom);
                    bus.master_req_i[i].addr  = $urandom;
                    bus.master_req_i[i].wdata = $urandom;
                end
            end
            drive(3'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), $urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- N-to-1 OBI arbiter that shares one slave port (peripheral system, memory bank or wrapper CSR) between several masters, e.g. the NHARTS core data ports.
- Round-robin arbitration on the address phase.
- Records the winner ID of every accepted transaction in an in-order FIFO and routes each response phase back to the master that issued it.
- Sits between core/external master ports and a single slave port inside the bus system.

Parameters:
- N_MASTERS, 3, number of requesting OBI masters (≥2).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (ID FIFO depth, ≥1).

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- master_req_i  input  N_MASTERS x obi_req_t  per-master OBI request (req, we, be, addr, wdata).
- master_resp_o  output  N_MASTERS x obi_resp_t  per-master gnt, rvalid, rdata.
- slave_req_o  output  obi_req_t  request to the shared slave.
- slave_resp_i  input  obi_resp_t  response from the shared slave.
- busy_o  output  1  high while the ID FIFO is non-empty.
- err_o  output  1  sticky: slave rvalid arrived with no transaction outstanding.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values:
  - rr pointer = 0; lock clear; ID FIFO empty.
  - err_o = 0, busy_o = 0.
  - All master_resp_o fields = 0; slave_req_o.req = 0.
- Arbitration (combinational):
  - The winner is the first master with req=1, searching from the rr pointer upward with wrap-around N_MASTERS-1 → 0.
  - slave_req_o carries the winner's request fields.
  - slave_req_o.req = winner.req AND NOT fifo_full.
  - When no master requests, all slave_req_o fields are 0.
- Grant:
  - master_resp_o[winner].gnt = slave_resp_i.gnt AND slave_req_o.req.
  - All other masters see gnt = 0.
  - Zero-cycle pass-through; no added latency on either phase.
- Handshake (slave_req_o.req & slave_resp_i.gnt):
  - Push the winner ID into the FIFO.
  - rr pointer ← (winner+1) mod N_MASTERS.
- Lock (OBI stability):
  - If slave_req_o.req=1 and gnt=0, a lock register holds the current winner.
  - The next cycle must select that same master regardless of other requests or pointer.
  - Lock clears on the handshake.
  - A locked master dropping req is a protocol violation: the lock clears, and no other action is required.
- FIFO full:
  - slave_req_o.req is forced to 0 and no master is granted.
  - This holds even if a pop occurs in the same cycle (push-on-full is never allowed). The next cycle may grant.
  - The lock is not set while blocked by full.
- Response phase:
  - On slave_resp_i.rvalid with FIFO non-empty: master_resp_o[head].rvalid=1 and rdata=slave_resp_i.rdata in the same cycle; pop.
  - Other masters' rdata = 0.
- Empty FIFO + rvalid: response dropped, err_o ← 1 and stays set until reset.
- Simultaneous push and pop (FIFO not full): both take effect; occupancy unchanged.
- Single requester: it is granted every handshake; the pointer still rotates.
- Reset mid-transaction: the FIFO flushes; a late rvalid after reset sets err_o.
- Widths:
  - ID width = $clog2(N_MASTERS).
  - Occupancy counter width = $clog2(MAX_OUTSTANDING+1).
  - Pointer arithmetic wraps modulo depth (non-power-of-two depth supported).

Decomposition:
- cei_mochila_pkg gets the ID-width helper, the default MAX_OUTSTANDING constant and an arb_id_t typedef (sized for NHARTS+1 masters).
- obi_pkg types are reused unchanged.
- Sub-module obi_arb_id_fifo: parameterised circular FIFO with push, pop, head, full, empty and occupancy; same clk_i/rst_i. Arbitration, lock and routing stay in the top.

Test Plan:
- Masters 0, 1, 2 all hold req with the slave always gnt=1 and rvalid one cycle later → grants in order 0,1,2,0,1,2; each rdata (0xA0, 0xA1, 0xA2…) returns to the issuing master only.
- Master 1 requests with slave gnt=0 for 3 cycles, master 0 raising req in cycle 2 → slave_req_o stays master 1's addr (0x2000_0010) until gnt; master 0 is granted next.
- MAX_OUTSTANDING=2, slave grants but withholds rvalid → the third request sees slave_req_o.req=0 and busy_o=1; after one rvalid, the grant resumes the following cycle.
- Slave returns rvalid in the same cycle as a new handshake at occupancy 1 → occupancy stays 1; the response goes to the older ID.
- Spurious slave rvalid with FIFO empty → no master rvalid; err_o=1 and sticky until rst_i.
- rst_i asserted with 2 outstanding → all outputs reset immediately (async); the pointer restarts at master 0.
